// File: rtl/z0_seq_ctrl_pkg.sv
// z0_seq_ctrl_pkg: opcode constants, state encoding and bus word type for the z0 sequencer
package z0_seq_ctrl_pkg;
    typedef logic [15:0] word_t;
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MOVE  = 8'h01;
    localparam logic [7:0] OP_LOAD  = 8'h02;
    localparam logic [7:0] OP_STORE = 8'h03;
    localparam logic [7:0] OP_HALT  = 8'hFF;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
endpackage

// File: rtl/z0_seq_ctrl_if.sv
// z0_seq_ctrl_if: single-port memory bus with req/ack handshake
interface z0_seq_ctrl_if;
    import z0_seq_ctrl_pkg::*;
    logic  mem_req;
    logic  mem_we;
    word_t mem_addr;
    word_t mem_wdata;
    word_t mem_rdata;
    logic  mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/z0_seq_ctrl.sv
// z0_seq_ctrl: fetch/decode/execute sequencer owning PC, IR and the memory bus
module z0_seq_ctrl
    import z0_seq_ctrl_pkg::*;
#(
    parameter word_t RESET_PC    = 16'h0000,
    parameter int    ACK_TIMEOUT = 255
) (
    input  logic  clk,
    input  logic  rst,
    z0_seq_ctrl_if.master bus,
    input  word_t mar,
    input  word_t mdr,
    output word_t ir,
    output logic  exec_en,
    output logic  mdr_load,
    output word_t mdr_load_data,
    output word_t pc,
    output logic  halted,
    output logic  illegal,
    output logic  bus_err
);
    localparam word_t TO = word_t'(ACK_TIMEOUT);

    state_t state, state_n;
    word_t  cnt, cnt_n, pc_n, ir_n, addr_n, wdata_n, ld_n;
    logic   req_n, we_n, exec_n, mdr_load_n, halted_n, illegal_n, bus_err_n;
    logic   wait_ack, timeout;

    assign wait_ack = bus.mem_req && !bus.mem_ack;
    assign timeout  = (ACK_TIMEOUT != 0) && wait_ack && (cnt + 16'd1 == TO);

    // Next state and next register values; DECODE and EXEC pre-raise the fetch request so NOP/MOVE avoid a dead cycle
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pc_n       = pc;
        ir_n       = ir;
        req_n      = bus.mem_req;
        we_n       = bus.mem_we;
        addr_n     = bus.mem_addr;
        wdata_n    = bus.mem_wdata;
        ld_n       = mdr_load_data;
        exec_n     = 1'b0;
        mdr_load_n = 1'b0;
        halted_n   = halted;
        illegal_n  = illegal;
        bus_err_n  = bus_err;
        case (state)
            S_FETCH: begin
                if (!bus.mem_req) begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = pc;
                end else if (bus.mem_ack) begin
                    ir_n    = bus.mem_rdata;
                    pc_n    = pc + 16'd1;
                    req_n   = 1'b0;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_FETCH;
                req_n   = 1'b1;
                we_n    = 1'b0;
                addr_n  = pc;
                cnt_n   = '0;
                case (ir[15:8])
                    OP_MOVE: begin
                        req_n   = 1'b0;
                        exec_n  = 1'b1;
                        state_n = S_EXEC;
                    end
                    OP_LOAD: begin
                        addr_n  = mar;
                        state_n = S_MEM;
                    end
                    OP_STORE: begin
                        addr_n  = mar;
                        wdata_n = mdr;
                        we_n    = 1'b1;
                        state_n = S_MEM;
                    end
                    OP_HALT: begin
                        req_n    = 1'b0;
                        halted_n = 1'b1;
                        state_n  = S_HALT;
                    end
                    OP_NOP: ;
                    default: illegal_n = 1'b1;
                endcase
            end
            S_EXEC: begin
                req_n   = 1'b1;
                we_n    = 1'b0;
                addr_n  = pc;
                cnt_n   = '0;
                state_n = S_FETCH;
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    req_n      = 1'b0;
                    mdr_load_n = !bus.mem_we;
                    ld_n       = bus.mem_we ? mdr_load_data : bus.mem_rdata;
                    cnt_n      = '0;
                    state_n    = S_FETCH;
                end
            end
            default: ;
        endcase
        if (wait_ack) cnt_n = cnt + 16'd1;
        if (timeout) begin
            req_n     = 1'b0;
            bus_err_n = 1'b1;
            halted_n  = 1'b1;
            state_n   = S_HALT;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            cnt           <= '0;
            pc            <= RESET_PC;
            ir            <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            mdr_load_data <= '0;
            exec_en       <= 1'b0;
            mdr_load      <= 1'b0;
            halted        <= 1'b0;
            illegal       <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            pc            <= pc_n;
            ir            <= ir_n;
            bus.mem_req   <= req_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_wdata <= wdata_n;
            mdr_load_data <= ld_n;
            exec_en       <= exec_n;
            mdr_load      <= mdr_load_n;
            halted        <= halted_n;
            illegal       <= illegal_n;
            bus_err       <= bus_err_n;
        end
    end
endmodule

// File: tb/tb_z0_seq_ctrl.sv
// tb_z0_seq_ctrl: directed and randomized checks of the z0 sequencer against an ISA-level model
module tb_z0_seq_ctrl;
    import z0_seq_ctrl_pkg::*;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mar = '0;
    logic [15:0] mdr = '0;
    logic [15:0] ir, mdr_load_data, pc;
    logic        exec_en, mdr_load, halted, illegal, bus_err;

    z0_seq_ctrl_if bus();

    z0_seq_ctrl #(.RESET_PC(16'hFFFF), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .mar(mar), .mdr(mdr), .ir(ir),
        .exec_en(exec_en), .mdr_load(mdr_load), .mdr_load_data(mdr_load_data),
        .pc(pc), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    logic [15:0] mem [0:65535];
    int          delay = 0;
    int          hang_addr = -1;
    int          wc = 0;
    tx_t         tx_q[$];
    logic [15:0] exec_q[$];
    logic [15:0] ld_q[$];
    logic [15:0] watch_addr = '0;
    int          watch_cnt = 0;
    int          we_ones = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Memory: acks after `delay` waiting cycles, never acks hang_addr
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (rst || !bus.mem_req || int'(bus.mem_addr) == hang_addr) wc = 0;
            else if (wc == delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                tx_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : mem[bus.mem_addr]});
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                wc = 0;
            end else wc++;
        end
    end

    // Strobe and bus-hold monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (exec_en) exec_q.push_back(ir);
                if (mdr_load) ld_q.push_back(mdr_load_data);
                if (bus.mem_req && bus.mem_addr == watch_addr) begin
                    watch_cnt++;
                    if (bus.mem_we) we_ones++;
                end
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        tx_q.delete();
        exec_q.delete();
        ld_q.delete();
        watch_cnt = 0;
        we_ones = 0;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic run_prog(output int cyc);
        cyc = 0;
        while (!halted && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!halted) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_bound halted=%0b after %0d cycles, required 1", halted, cyc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (pc !== 16'hFFFF || ir !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_pc_ir pc=%h ir=%h, required ffff 0000", pc, ir);
        end
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, mdr_load_data} !== 50'h0) begin
            n_fail++;
            $display("FAIL reset_bus req=%b we=%b addr=%h wdata=%h ld=%h, required all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, mdr_load_data);
        end
        n_tests++;
        if ({exec_en, mdr_load, halted, illegal, bus_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags %b, required 00000", {exec_en, mdr_load, halted, illegal, bus_err});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'hFFFF || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_fetch req=%b addr=%h we=%b, required 1 ffff 0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
    endtask

    task automatic test_move_halt;
        int cyc;
        mem[16'hFFFF] = 16'h0000;
        mem[16'h0000] = 16'h0184;
        mem[16'h0001] = 16'hFF00;
        delay = 0;
        do_reset();
        run_prog(cyc);
        n_tests++;
        if (tx_q.size() != 3 || tx_q[0] !== {1'b0, 16'hFFFF, 16'h0000} || tx_q[1] !== {1'b0, 16'h0000, 16'h0184}
            || tx_q[2] !== {1'b0, 16'h0001, 16'hFF00}) begin
            n_fail++;
            $display("FAIL move_fetches count=%0d, required 3 reads at ffff,0000,0001", tx_q.size());
        end
        n_tests++;
        if (exec_q.size() != 1 || exec_q[0] !== 16'h0184) begin
            n_fail++;
            $display("FAIL move_exec pulses=%0d, required 1 with ir=0184", exec_q.size());
        end
        n_tests++;
        if (pc !== 16'h0002 || cyc != 8 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL move_halt pc=%h cycles=%0d req=%b, required 0002 8 0", pc, cyc, bus.mem_req);
        end
    endtask

    task automatic test_load;
        int cyc;
        mem[16'hFFFF] = 16'h0200;
        mem[16'h0000] = 16'hFF00;
        mem[16'h0040] = 16'hBEEF;
        mar = 16'h0040;
        watch_addr = 16'h0040;
        delay = 3;
        do_reset();
        run_prog(cyc);
        n_tests++;
        if (watch_cnt != 4 || we_ones != 0) begin
            n_fail++;
            $display("FAIL load_hold req_cycles=%0d we_cycles=%0d, required 4 0", watch_cnt, we_ones);
        end
        n_tests++;
        if (ld_q.size() != 1 || ld_q[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_data pulses=%0d, required 1 with beef", ld_q.size());
        end
        n_tests++;
        if (tx_q.size() != 3 || tx_q[2] !== {1'b0, 16'h0000, 16'hFF00} || cyc != 16 || bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_next_fetch txs=%0d cycles=%0d bus_err=%b, required 3 16 0", tx_q.size(), cyc, bus_err);
        end
    endtask

    task automatic test_store;
        int cyc;
        mem[16'hFFFF] = 16'h0300;
        mem[16'h0000] = 16'hFF00;
        mem[16'h0010] = 16'h0000;
        mar = 16'h0010;
        mdr = 16'h1234;
        watch_addr = 16'h0010;
        delay = 3;
        do_reset();
        fork
            run_prog(cyc);
            begin
                for (int i = 0; i < 50 && !(bus.mem_req && bus.mem_addr == 16'h0010); i++) @(negedge clk);
                mdr = 16'h0000;
            end
        join
        n_tests++;
        if (mem[16'h0010] !== 16'h1234 || tx_q.size() != 3 || tx_q[1] !== {1'b1, 16'h0010, 16'h1234}) begin
            n_fail++;
            $display("FAIL store_write mem=%h txs=%0d, required 1234 3", mem[16'h0010], tx_q.size());
        end
        n_tests++;
        if (watch_cnt != 4 || we_ones != 4) begin
            n_fail++;
            $display("FAIL store_hold req_cycles=%0d we_cycles=%0d, required 4 4", watch_cnt, we_ones);
        end
    endtask

    task automatic test_illegal;
        int cyc;
        mem[16'hFFFF] = 16'h7A00;
        mem[16'h0000] = 16'h0000;
        mem[16'h0001] = 16'hFF00;
        delay = $urandom_range(0, 2);
        do_reset();
        run_prog(cyc);
        n_tests++;
        if (illegal !== 1'b1 || pc !== 16'h0002 || cyc != 7 + 3 * delay || exec_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_run illegal=%b pc=%h cycles=%0d, required 1 0002 %0d", illegal, pc, cyc, 7 + 3 * delay);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (illegal !== 1'b1 || pc !== 16'h0002 || ir !== 16'hFF00 || bus.mem_req !== 1'b0 || tx_q.size() != 3) begin
            n_fail++;
            $display("FAIL illegal_frozen illegal=%b pc=%h ir=%h req=%b, required 1 0002 ff00 0", illegal, pc, ir, bus.mem_req);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        mem[16'hFFFF] = 16'h0000;
        hang_addr = 32'hFFFF;
        watch_addr = 16'hFFFF;
        delay = 0;
        do_reset();
        run_prog(cyc);
        n_tests++;
        if (watch_cnt != 4 || cyc != 5 || bus_err !== 1'b1 || halted !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err req_cycles=%0d cycles=%0d bus_err=%b halted=%b, required 4 5 1 1",
                     watch_cnt, cyc, bus_err, halted);
        end
        mem[16'hFFFF] = 16'hFF00;
        hang_addr = -1;
        delay = 3;
        do_reset();
        run_prog(cyc);
        n_tests++;
        if (watch_cnt != 4 || cyc != 6 || bus_err !== 1'b0 || pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_ack_wins req_cycles=%0d cycles=%0d bus_err=%b pc=%h, required 4 6 0 0000",
                     watch_cnt, cyc, bus_err, pc);
        end
    endtask

    task automatic test_reset_mid;
        mem[16'hFFFF] = 16'h7A00;
        mem[16'h0000] = 16'h0200;
        mar = 16'h2000;
        hang_addr = 32'h2000;
        delay = 0;
        do_reset();
        for (int i = 0; i < 40 && !(bus.mem_req && bus.mem_addr == 16'h2000); i++) @(negedge clk);
        n_tests++;
        if (illegal !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h2000) begin
            n_fail++;
            $display("FAIL rstmid_wait illegal=%b req=%b addr=%h, required 1 1 2000", illegal, bus.mem_req, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.mem_req !== 1'b0 || pc !== 16'hFFFF || {illegal, halted, bus_err} !== 3'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear req=%b pc=%h flags=%b, required 0 ffff 000", bus.mem_req, pc, {illegal, halted, bus_err});
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'hFFFF || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_refetch req=%b addr=%h we=%b, required 1 ffff 0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        hang_addr = -1;
    endtask

    task automatic test_random;
        for (int p = 0; p < 20; p++) begin
            logic [15:0] a, ins, m;
            logic [7:0]  op;
            logic        exp_ill, ok;
            int          n, cost, cyc;
            tx_t         etx[$];
            logic [15:0] eex[$];
            logic [15:0] eld[$];
            delay = $urandom_range(0, 3);
            mar = 16'h1000 + 16'($urandom_range(0, 255));
            mdr = 16'($urandom);
            m = 16'($urandom);
            mem[mar] = m;
            n = $urandom_range(1, 8);
            a = 16'hFFFF;
            for (int i = 0; i <= n; i++) begin
                case ($urandom_range(0, 4))
                    0: op = 8'h00;
                    1: op = 8'h01;
                    2: op = 8'h02;
                    3: op = 8'h03;
                    default: op = 8'($urandom_range(4, 254));
                endcase
                if (i == n) op = 8'hFF;
                mem[a] = {op, 8'($urandom)};
                a++;
            end
            a = 16'hFFFF;
            cost = 1;
            exp_ill = 1'b0;
            for (int i = 0; i <= n; i++) begin
                ins = mem[a];
                etx.push_back({1'b0, a, ins});
                a++;
                cost += delay;
                case (ins[15:8])
                    8'h00: cost += 2;
                    8'h01: begin cost += 3; eex.push_back(ins); end
                    8'h02: begin cost += 4 + delay; etx.push_back({1'b0, mar, m}); eld.push_back(m); end
                    8'h03: begin cost += 4 + delay; etx.push_back({1'b1, mar, mdr}); m = mdr; end
                    8'hFF: cost += 2;
                    default: begin cost += 2; exp_ill = 1'b1; end
                endcase
            end
            do_reset();
            run_prog(cyc);
            n_tests++;
            if (cyc != cost || pc !== a || illegal !== exp_ill || bus_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_state p=%0d cycles=%0d pc=%h illegal=%b bus_err=%b, required %0d %h %b 0",
                         p, cyc, pc, illegal, bus_err, cost, a, exp_ill);
            end
            ok = (tx_q.size() == etx.size());
            for (int i = 0; ok && i < etx.size(); i++) if (tx_q[i] !== etx[i]) ok = 1'b0;
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand_bus p=%0d txs=%0d, required %0d matching transfers", p, tx_q.size(), etx.size());
            end
            ok = (exec_q.size() == eex.size()) && (ld_q.size() == eld.size());
            for (int i = 0; ok && i < eex.size(); i++) if (exec_q[i] !== eex[i]) ok = 1'b0;
            for (int i = 0; ok && i < eld.size(); i++) if (ld_q[i] !== eld[i]) ok = 1'b0;
            n_tests++;
            if (!ok || mem[mar] !== m) begin
                n_fail++;
                $display("FAIL rand_strobes p=%0d exec=%0d ld=%0d mem=%h, required %0d %0d %h",
                         p, exec_q.size(), ld_q.size(), mem[mar], eex.size(), eld.size(), m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_move_halt();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/z0_seq_ctrl.md
Name: z0_seq_ctrl

Overview:
- Fetch/decode/execute sequencer for the z0 CPU.
- Owns the PC and the instruction register, and drives the single-port memory bus with a req/ack handshake.
- Issues a one-cycle execute strobe so the register-move datapath (X/Y/MAR/MDR) commits the current instruction.
- Performs the MAR/MDR memory transfers for LOAD/STORE, and halts on HALT or on a bus timeout.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ACK_TIMEOUT, 255, maximum cycles to wait for mem_ack in any bus state; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- mem_req  output  1  bus request, held until ack
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  output  16  bus address
- mem_wdata  output  16  write data
- mem_rdata  input  16  read data, valid when mem_ack is high
- mem_ack  input  1  transfer complete, one-cycle pulse
- mar  input  16  current MAR from the datapath
- mdr  input  16  current MDR from the datapath
- ir  output  16  instruction register, presented to the datapath
- exec_en  output  1  one-cycle strobe: datapath commits ir (MOVE)
- mdr_load  output  1  one-cycle strobe: datapath loads mdr_load_data into MDR
- mdr_load_data  output  16  LOAD result
- pc  output  16  program counter
- halted  output  1  core stopped
- illegal  output  1  sticky: undefined opcode seen
- bus_err  output  1  sticky: ack timeout occurred

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and dominates all other inputs. All outputs are registered.
- Reset values:
  - pc = RESET_PC; state = FETCH.
  - ir, mem_addr, mem_wdata and mdr_load_data = 0.
  - mem_req, mem_we, exec_en, mdr_load, halted, illegal and bus_err = 0.
  - Timeout counter = 0.
- Reset mid-transfer: mem_req drops at the reset edge. The memory shares rst, so no stale ack is expected.
- Opcode field is ir[15:8]. Constants:
  - OP_NOP = 8'h00, OP_MOVE = 8'h01, OP_LOAD = 8'h02, OP_STORE = 8'h03, OP_HALT = 8'hFF.
- FETCH state:
  - mem_req = 1, mem_we = 0, mem_addr = pc.
  - On the cycle mem_ack is sampled high: ir <= mem_rdata; pc <= pc + 1 (16'hFFFF wraps to 16'h0000); mem_req <= 0; next state DECODE.
- DECODE state (1 cycle), by opcode:
  - MOVE: next state EXEC.
  - LOAD: latch mem_addr <= mar, mem_we <= 0, mem_req <= 1; next state MEM.
  - STORE: latch mem_addr <= mar, mem_wdata <= mdr, mem_we <= 1, mem_req <= 1; next state MEM.
  - HALT: halted <= 1; next state HALT.
  - NOP: next state FETCH.
  - Any other opcode: illegal <= 1 (sticky), treated as NOP.
- EXEC state: exec_en = 1 for exactly this cycle; next state FETCH.
- MEM state:
  - mem_addr, mem_wdata and mem_we are held stable until ack (later MAR/MDR changes are ignored).
  - On ack: mem_req <= 0. For a read, mdr_load <= 1 for one cycle with mdr_load_data <= mem_rdata. Next state FETCH.
- Handshake rules:
  - Zero-wait ack (ack on the first cycle req is visible) is legal.
  - mem_ack while mem_req = 0 is ignored.
  - req never drops before ack except on reset or timeout.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each cycle req is high without ack.
  - If ACK_TIMEOUT != 0 and the counter reaches ACK_TIMEOUT: mem_req <= 0, bus_err <= 1, halted <= 1, state HALT.
  - An ack on the same cycle the count reaches ACK_TIMEOUT wins: transfer completes, no error.
- HALT state: all strobes 0, mem_req = 0, pc and ir frozen. The only exit is rst.
- Throughput with zero-wait memory: NOP = 2 cycles, MOVE = 3 cycles, LOAD/STORE = 4 cycles.

Decomposition:
- Shared include z0_defs: opcode constants (OP_NOP, OP_MOVE, OP_LOAD, OP_STORE, OP_HALT) and the state encodings. The existing mov logic uses the same OP_MOVE.
- No sub-module needed. The timeout counter stays inline.

Test Plan:
- Reset, memory holds [0]=16'h0184 (MOVE), [1]=16'hFF00, zero-wait ack -> fetch addr 0000; exec_en one cycle at cycle 3 with ir=16'h0184; fetch addr 0001; halted=1; pc=16'h0002.
- LOAD with mar=16'h0040, mem[0x40]=16'hBEEF, 3-cycle ack delay -> mem_addr=16'h0040 and mem_we=0 held for 3 cycles; mdr_load pulse with mdr_load_data=16'hBEEF; next fetch.
- STORE with mar=16'h0010, mdr=16'h1234, mdr changed to 0 during wait -> write of 16'h1234 to 16'h0010, mem_we=1 until ack.
- Opcode 8'h7A then NOP -> illegal=1 and stays 1, execution continues; pc wraps: RESET_PC=16'hFFFF, second fetch addr 16'h0000.
- ACK_TIMEOUT=4, ack never arrives -> req high exactly 4 cycles then drops; bus_err=1, halted=1. Repeat with ack on the 4th cycle -> no error.
- rst asserted during MEM wait -> next cycle mem_req=0, pc=RESET_PC, sticky flags cleared, fetch restarts.
